// File: rtl/shade_pixel_fifo_if.sv
// Pixel bus between the shader pipeline, the scan-out timing and shade_pixel_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface shade_pixel_fifo_if #(
    parameter int unsigned ADDR_WIDTH = 6
);
    logic [7:0]          red_in;
    logic [7:0]          green_in;
    logic [7:0]          blue_in;
    logic                color_valid;
    logic                full;
    logic                almost_full;
    logic [ADDR_WIDTH:0] level;
    logic                pix_req;
    logic [7:0]          pix_red;
    logic [7:0]          pix_green;
    logic [7:0]          pix_blue;
    logic                pix_valid;
    logic                frame_sync;
    logic                err_clear;
    logic                overflow_err;
    logic                underflow_err;

    modport master (
        output red_in, green_in, blue_in, color_valid, pix_req, frame_sync, err_clear,
        input  full, almost_full, level, pix_red, pix_green, pix_blue, pix_valid,
               overflow_err, underflow_err
    );

    modport slave (
        input  red_in, green_in, blue_in, color_valid, pix_req, frame_sync, err_clear,
        output full, almost_full, level, pix_red, pix_green, pix_blue, pix_valid,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/shade_pixel_fifo.sv
// Circular pixel buffer between the shader and scan-out, flushed on frame_sync.
// Optional SHADE_FIFO_REPEAT_LAST_EN: underflow reads repeat the last popped pixel.
module shade_pixel_fifo #(
    parameter int unsigned DEPTH             = 64,
    parameter int unsigned ADDR_WIDTH        = 6,
    parameter int unsigned ALMOST_FULL_LEVEL = 56,
    parameter logic [23:0] UNDERFLOW_RGB     = 24'h000000
) (
    input  logic                clk,
    input  logic                rst_n,
    shade_pixel_fifo_if.slave   bus
);
    localparam int unsigned LVL_W = ADDR_WIDTH + 1;
    localparam int unsigned RGB_W = 24;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL_LEVEL);

    logic [RGB_W-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic [RGB_W-1:0]      pix_rgb_q, pix_rgb_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  overflow_err_q, overflow_err_d;
    logic                  underflow_err_q, underflow_err_d;

    logic                  wr_en_c;
    logic                  rd_en_c;
    logic                  empty_c;
    logic [RGB_W-1:0]      wr_rgb_c;
    logic [RGB_W-1:0]      under_rgb_c;
    logic [RGB_W-1:0]      rd_rgb_c;

`ifdef SHADE_FIFO_REPEAT_LAST_EN
    logic [RGB_W-1:0]      last_rgb_q, last_rgb_d;
    logic                  last_vld_q, last_vld_d;
`endif

    // Accept/pop decisions use start-of-cycle occupancy; frame_sync overrides both.
    always_comb begin
        empty_c     = (level_q == '0);
        wr_rgb_c    = {bus.red_in, bus.green_in, bus.blue_in};
        rd_rgb_c    = mem_q[rd_ptr_q];
        wr_en_c     = bus.color_valid && !full_q && !bus.frame_sync;
        rd_en_c     = bus.pix_req && !empty_c && !bus.frame_sync;
        under_rgb_c = UNDERFLOW_RGB;
`ifdef SHADE_FIFO_REPEAT_LAST_EN
        if (last_vld_q && !bus.frame_sync) begin
            under_rgb_c = last_rgb_q;
        end
`endif
    end

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        pix_rgb_d       = pix_rgb_q;
        pix_valid_d     = bus.pix_req;
        overflow_err_d  = overflow_err_q;
        underflow_err_d = underflow_err_q;
`ifdef SHADE_FIFO_REPEAT_LAST_EN
        last_rgb_d      = last_rgb_q;
        last_vld_d      = last_vld_q;
`endif

        if (bus.frame_sync) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            case ({wr_en_c, rd_en_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end

        full_d        = (level_d == LVL_FULL);
        almost_full_d = (level_d >= LVL_AF);

        if (rd_en_c) begin
            pix_rgb_d = rd_rgb_c;
        end else if (bus.pix_req) begin
            pix_rgb_d = under_rgb_c;
        end

`ifdef SHADE_FIFO_REPEAT_LAST_EN
        if (bus.frame_sync) begin
            last_vld_d = 1'b0;
        end else if (rd_en_c) begin
            last_rgb_d = rd_rgb_c;
            last_vld_d = 1'b1;
        end
`endif

        // A fresh error event wins over err_clear in the same cycle.
        if (bus.color_valid && full_q && !bus.frame_sync) begin
            overflow_err_d = 1'b1;
        end else if (bus.err_clear) begin
            overflow_err_d = 1'b0;
        end
        if (bus.pix_req && empty_c && !bus.frame_sync) begin
            underflow_err_d = 1'b1;
        end else if (bus.err_clear) begin
            underflow_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            full_q          <= 1'b0;
            almost_full_q   <= 1'b0;
            pix_rgb_q       <= '0;
            pix_valid_q     <= 1'b0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
`ifdef SHADE_FIFO_REPEAT_LAST_EN
            last_rgb_q      <= '0;
            last_vld_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            full_q          <= full_d;
            almost_full_q   <= almost_full_d;
            pix_rgb_q       <= pix_rgb_d;
            pix_valid_q     <= pix_valid_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
`ifdef SHADE_FIFO_REPEAT_LAST_EN
            last_rgb_q      <= last_rgb_d;
            last_vld_q      <= last_vld_d;
`endif
        end
    end

    // Storage is not reset; only live entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            mem_q[wr_ptr_q] <= wr_rgb_c;
        end
    end

    assign bus.full          = full_q;
    assign bus.almost_full   = almost_full_q;
    assign bus.level         = level_q;
    assign bus.pix_red       = pix_rgb_q[23:16];
    assign bus.pix_green     = pix_rgb_q[15:8];
    assign bus.pix_blue      = pix_rgb_q[7:0];
    assign bus.pix_valid     = pix_valid_q;
    assign bus.overflow_err  = overflow_err_q;
    assign bus.underflow_err = underflow_err_q;
endmodule
